timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
- Controller that sequences a prescaled up-counter to build a run/pause/stop timer for the game logic.
- Owns a divide-by-DIV prescaler whose wrap produces a one-cycle `tick` enable; counts ticks into `elapsed` until a loaded target is reached.
- Arbitrates the user commands (clear, load, start, pause) into a 4-state FSM that gates the prescaler.
- Sits between the debounced button/command logic and the display and game-state blocks.

Parameters:
- DIV, 50000000, prescaler period in NEclk cycles per tick (must be >= 2).
- PRE_BITS, 29, prescaler width (2^PRE_BITS >= DIV).
- T_BITS, 16, width of target and elapsed count.

Ports:
- NEclk  in  1  clock; all state updates on its falling edge.
- reset  in  1  synchronous, active-low reset, sampled on the falling edge of NEclk.
- clear  in  1  abort the run and zero the counts (level, sampled each edge).
- load  in  1  latch `target_in` into the target register.
- target_in  in  T_BITS  terminal tick count; 0 means free-run, no terminal.
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- tick  out  1  one-cycle pulse on each prescaler wrap while RUN.
- elapsed  out  T_BITS  ticks counted since the last clear.
- done  out  1  one-cycle pulse when `elapsed` reaches the target.
- state  out  2  current state: 0 IDLE, 1 RUN, 2 PAUSED, 3 DONE.
- busy  out  1  high in RUN or PAUSED.

Behaviour:
- **Reset** (reset==0 on a falling edge):
  - state=IDLE, prescaler=0, elapsed=0, target=0.
  - tick=0, done=0, busy=0.
  - Reset overrides every other input.
- **Command priority** each edge: clear > load > start > pause.
  - Only the highest-priority asserted command acts.
  - load is accepted only in IDLE or DONE; it is ignored in RUN and PAUSED.
- **clear**, from any state:
  - state→IDLE, prescaler=0, elapsed=0, tick=0, done=0.
  - target is kept.
- **IDLE**:
  - start→RUN; prescaler stays 0 on entry.
  - pause is ignored.
- **RUN**:
  - If prescaler==DIV-1: prescaler=0, tick=1, elapsed=elapsed+1. Otherwise prescaler+1, tick=0.
  - pause→PAUSED: prescaler and elapsed freeze, and tick is 0 on that same edge even if a wrap was due. The wrap is deferred, not lost.
  - start while in RUN has no effect.
- **PAUSED**:
  - start→RUN; counting resumes from the frozen prescaler value.
  - pause has no effect.
- **Terminal count**:
  - When target!=0 and the tick increment makes elapsed==target, on the same edge: state→DONE, done=1 for exactly one cycle.
  - tick is also 1 on that edge.
- **DONE**:
  - Prescaler held at 0, elapsed held.
  - start→RUN with elapsed=0 (restart).
  - load updates target and stays in DONE.
- **Free-run** (target==0): elapsed wraps from 2^T_BITS-1 to 0 without asserting done.
- **Latency**: the first tick after start from IDLE occurs exactly DIV edges after the edge that accepted start.
- **Output timing**: tick, done and elapsed are registered and change only on NEclk falling edges. busy and state are decoded from the state register.
- **Simultaneous events**:
  - clear together with a wrap: clear wins, no tick, no done.
  - pause together with a terminal wrap: pause wins, the wrap is deferred and DONE occurs after resume.

Test Plan (DIV=4, T_BITS=8):
- **Reset**: hold reset=0 for 3 edges with start=1 → state=0, elapsed=0, tick=0, busy=0; release reset, one edge later state=1.
- **Basic run**: load target=3, start for one edge → tick pulses at edges 4, 8 and 12 after start. elapsed goes 1,2,3. done=1 and state=3 at edge 12 only; elapsed holds 3 afterwards.
- **Pause mid-period**: run 6 edges (elapsed=1, prescaler=1), pause for 10 edges, then start → no tick while paused; the next tick is 3 edges after resume; elapsed=2.
- **Clear and load priority**:
  - clear+start together in RUN → IDLE, elapsed=0.
  - load=1 with target_in=9 while RUN → target unchanged.
- **Free-run wrap**: target=0, run 256 ticks → elapsed returns to 0, done never asserted.
- **Restart from DONE**: start in DONE → state=1, elapsed=0, and the next done follows after target×DIV edges.

Source files
------------

// File: rtl/timer_sequencer.sv
// Run/pause/stop timer: a divide-by-DIV prescaler gated by a 4-state FSM,
// counting prescaler wraps into elapsed until an optional target is reached.
module timer_sequencer #(
  parameter int DIV      = 50000000,
  parameter int PRE_BITS = 29,
  parameter int T_BITS   = 16
) (
  input  logic              NEclk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [T_BITS-1:0] target_in,
  input  logic              start,
  input  logic              pause,
  output logic              tick,
  output logic [T_BITS-1:0] elapsed,
  output logic              done,
  output logic [1:0]        state,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(DIV - 1);

  state_t              state_reg, state_next;
  logic [PRE_BITS-1:0] pre_reg, pre_next;
  logic [T_BITS-1:0]   elapsed_reg, elapsed_next;
  logic [T_BITS-1:0]   target_reg, target_next;
  logic                tick_reg, tick_next;
  logic                done_reg, done_next;
  logic [T_BITS-1:0]   elapsed_inc;

  assign elapsed_inc = elapsed_reg + T_BITS'(1);

  always_ff @(negedge NEclk) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      pre_reg     <= '0;
      elapsed_reg <= '0;
      target_reg  <= '0;
      tick_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pre_reg     <= pre_next;
      elapsed_reg <= elapsed_next;
      target_reg  <= target_next;
      tick_reg    <= tick_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pre_next     = pre_reg;
    elapsed_next = elapsed_reg;
    target_next  = target_reg;
    tick_next    = 1'b0;
    done_next    = 1'b0;

    if (clear) begin
      state_next   = S_IDLE;
      pre_next     = '0;
      elapsed_next = '0;
    end else if (load && (state_reg == S_IDLE || state_reg == S_DONE)) begin
      target_next = target_in;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (start) state_next = S_RUN;
        end
        S_RUN: begin
          // start outranks pause, and start has no effect while running
          if (pause && !start) begin
            state_next = S_PAUSED;
          end else if (pre_reg == PRE_LAST) begin
            pre_next     = '0;
            tick_next    = 1'b1;
            elapsed_next = elapsed_inc;
            if (target_reg != '0 && elapsed_inc == target_reg) begin
              state_next = S_DONE;
              done_next  = 1'b1;
            end
          end else begin
            pre_next = pre_reg + PRE_BITS'(1);
          end
        end
        S_PAUSED: begin
          if (start) state_next = S_RUN;
        end
        S_DONE: begin
          pre_next = '0;
          if (start) begin
            state_next   = S_RUN;
            elapsed_next = '0;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign tick    = tick_reg;
  assign done    = done_reg;
  assign elapsed = elapsed_reg;
  assign state   = state_reg;
  assign busy    = (state_reg == S_RUN) || (state_reg == S_PAUSED);

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed vector bench for timer_sequencer with DIV=4, T_BITS=8.
module tb_timer_sequencer;

  logic       NEclk = 1'b1;
  logic       reset, clear, load, start, pause;
  logic [7:0] target_in;
  logic       tick, done, busy;
  logic [7:0] elapsed;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  timer_sequencer #(.DIV(4), .PRE_BITS(3), .T_BITS(8)) dut (
    .NEclk(NEclk), .reset(reset), .clear(clear), .load(load),
    .target_in(target_in), .start(start), .pause(pause),
    .tick(tick), .elapsed(elapsed), .done(done), .state(state), .busy(busy)
  );

  always #5 NEclk = ~NEclk;

  typedef struct {
    logic       rst, clr, ld, st, pa;
    logic [7:0] tin;
    logic       etick;
    logic [7:0] eel;
    logic       edone;
    logic [1:0] estate;
  } vec_t;

  vec_t vq[$];

  task automatic p(input logic rst, clr, ld, st, pa, input logic [7:0] tin,
                   input logic etick, input logic [7:0] eel,
                   input logic edone, input logic [1:0] estate);
    vec_t v;
    v.rst = rst; v.clr = clr; v.ld = ld; v.st = st; v.pa = pa; v.tin = tin;
    v.etick = etick; v.eel = eel; v.edone = edone; v.estate = estate;
    vq.push_back(v);
  endtask

  task automatic idle(input int n, input logic [7:0] el, input logic [1:0] st);
    for (int k = 0; k < n; k++) p(1, 0, 0, 0, 0, 0, 0, el, 0, st);
  endtask

  task automatic tk(input logic [7:0] el, input logic [1:0] st);
    p(1, 0, 0, 0, 0, 0, 1, el, 0, st);
  endtask

  // Full 12-edge run to terminal count 3 after a start edge that left elapsed at 0.
  task automatic run_to_done();
    idle(3, 0, 1); tk(1, 1); idle(3, 1, 1); tk(2, 1); idle(3, 2, 1);
    p(1, 0, 0, 0, 0, 0, 1, 3, 1, 3);
  endtask

  task automatic drive(input logic rst, clr, ld, st, pa, input logic [7:0] tin);
    reset = rst; clear = clr; load = ld; start = st; pause = pa; target_in = tin;
    @(negedge NEclk);
    #1;
  endtask

  initial begin
    int ticks, dones;
    logic ebusy;
    drive(0, 0, 0, 0, 0, 0);

    // reset held with start asserted, then release
    for (int k = 0; k < 3; k++) p(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    p(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    // basic run to target 3
    p(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    p(1, 0, 1, 0, 0, 3, 0, 0, 0, 0);
    p(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_to_done();
    idle(2, 3, 3);
    // pause mid-period, resume, load ignored while running
    p(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    p(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    idle(3, 0, 1); tk(1, 1); idle(1, 1, 1);
    for (int k = 0; k < 10; k++) p(1, 0, 0, 0, 1, 0, 0, 1, 0, 2);
    p(1, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    idle(2, 1, 1); tk(2, 1);
    p(1, 0, 1, 0, 0, 9, 0, 2, 0, 1);
    idle(2, 2, 1);
    p(1, 0, 0, 0, 0, 0, 1, 3, 1, 3);
    // restart from DONE
    p(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    run_to_done();
    // pause coinciding with the terminal wrap defers it
    p(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    idle(3, 0, 1); tk(1, 1); idle(3, 1, 1); tk(2, 1); idle(3, 2, 1);
    p(1, 0, 0, 0, 1, 0, 0, 2, 0, 2);
    p(1, 0, 0, 1, 0, 0, 0, 2, 0, 1);
    p(1, 0, 0, 0, 0, 0, 1, 3, 1, 3);
    // clear+start on a due wrap: clear wins
    p(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    idle(3, 0, 1);
    p(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // pause ignored in IDLE
    p(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].clr, vq[i].ld, vq[i].st, vq[i].pa, vq[i].tin);
      ebusy = (vq[i].estate == 2'd1) || (vq[i].estate == 2'd2);
      checks++;
      if (tick !== vq[i].etick || elapsed !== vq[i].eel || done !== vq[i].edone ||
          state !== vq[i].estate || busy !== ebusy) begin
        errors++;
        $display("FAIL vec%0d: got tick=%b el=%0d done=%b state=%0d busy=%b, want tick=%b el=%0d done=%b state=%0d busy=%b",
                 i, tick, elapsed, done, state, busy,
                 vq[i].etick, vq[i].eel, vq[i].edone, vq[i].estate, ebusy);
      end else begin
        $display("vec%0d ok: tick=%b el=%0d done=%b state=%0d", i, tick, elapsed, done, state);
      end
    end

    // free-run with target 0: 256 ticks wrap elapsed back to 0, never done
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    ticks = 0; dones = 0;
    for (int i = 1; i <= 1024; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      ticks += int'(tick);
      dones += int'(done);
      if (i == 4 || i == 512 || i == 1024) begin
        checks++;
        if (tick !== 1'b1 || elapsed !== 8'((i / 4) % 256) || state !== 2'd1) begin
          errors++;
          $display("FAIL freerun edge%0d: got tick=%b el=%0d state=%0d, want tick=1 el=%0d state=1",
                   i, tick, elapsed, state, (i / 4) % 256);
        end else begin
          $display("freerun edge%0d ok: el=%0d", i, elapsed);
        end
      end
    end
    checks++;
    if (ticks != 256 || dones != 0) begin
      errors++;
      $display("FAIL freerun counts: got ticks=%0d dones=%0d, want ticks=256 dones=0", ticks, dones);
    end else begin
      $display("freerun counts ok: ticks=%0d dones=%0d", ticks, dones);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
